int_to_float: RTL

- Multi-cycle converter from 32-bit integer (signed or unsigned, chosen per transaction) to IEEE-754 single precision.
- Rounding is round-to-nearest-even (RNE).
- Produces float operands for the floating-point compare/arithmetic units.
- Valid/ready on both sides; one conversion in flight; serial leading-zero normalization.

---
 rtl/fp_pkg.sv | 18 +
 rtl/fp_round_rne.sv | 31 +++
 rtl/int_to_float.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point constants and the integer-to-float state encoding.
// Also imported by the float compare/add units.
package fp_pkg;

   localparam int unsigned FP_EXP_BIAS = 127;
   localparam int unsigned FP_EXP_W    = 8;
   localparam int unsigned FP_MANT_W   = 23;

   localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } fp_state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalized 32-bit magnitude (leading one at bit 31)
// into a packed single-precision {exp, mant} field. Purely combinational.
module fp_round_rne
   import fp_pkg::*;
(
   input  logic [31:0]                   mag_in,
   input  logic [8:0]                    exp_in,
   output logic [FP_EXP_W+FP_MANT_W-1:0] exp_mant_out,
   output logic                          inexact_out
);

   logic [FP_MANT_W-1:0] mant;
   logic                 guard;
   logic                 sticky;
   logic                 round_up;
   logic [FP_MANT_W:0]   mant_sum;
   logic [FP_EXP_W-1:0]  exp_out;

   always_comb begin
      mant     = mag_in[30:8];
      guard    = mag_in[7];
      sticky   = |mag_in[6:0];
      round_up = guard & (sticky | mant[0]);
      mant_sum = {1'b0, mant} + {{FP_MANT_W{1'b0}}, round_up};
      // A carry out of the mantissa leaves it all-zero and bumps the exponent.
      exp_out  = FP_EXP_W'(exp_in + {8'd0, mant_sum[FP_MANT_W]});
      exp_mant_out = {exp_out, mant_sum[FP_MANT_W-1:0]};
      inexact_out  = guard | sticky;
   end

endmodule

// File: rtl/int_to_float.sv
// Multi-cycle 32-bit integer (signed or unsigned) to IEEE-754 single converter.
// Serial leading-zero normalization, then one RNE rounding cycle.
module int_to_float
   import fp_pkg::*;
#(
   parameter int unsigned NORM_STEP = 1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_signed,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_inexact
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready, and DONE holds the result stable.

   fp_state_e   state_q, state_d;
   logic [31:0] mag_q, mag_d;
   logic [8:0]  exp_q, exp_d;
   logic        sign_q, sign_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_inexact_q, out_inexact_d;

   logic        accept;
   logic        in_neg;
   logic [31:0] in_mag;
   logic [FP_EXP_W+FP_MANT_W-1:0] rnd_exp_mant;
   logic        rnd_inexact;

   assign accept = in_valid & in_ready;
   assign in_neg = in_signed & in_data[31];
   // The most negative value negates onto itself, which is the correct magnitude.
   assign in_mag = in_neg ? (~in_data + 32'd1) : in_data;

   fp_round_rne u_round (
      .mag_in       (mag_q),
      .exp_in       (exp_q),
      .exp_mant_out (rnd_exp_mant),
      .inexact_out  (rnd_inexact)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         mag_q         <= '0;
         exp_q         <= '0;
         sign_q        <= 1'b0;
         out_data_q    <= FP_POS_ZERO;
         out_inexact_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mag_q         <= mag_d;
         exp_q         <= exp_d;
         sign_q        <= sign_d;
         out_data_q    <= out_data_d;
         out_inexact_q <= out_inexact_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (in_mag == 32'd0) ? DONE : NORM;
         NORM:    if (mag_q[31]) state_d = ROUND;
         ROUND:   state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   // Datapath
   always_comb begin
      mag_d         = mag_q;
      exp_d         = exp_q;
      sign_d        = sign_q;
      out_data_d    = out_data_q;
      out_inexact_d = out_inexact_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sign_d = in_neg;
               mag_d  = in_mag;
               exp_d  = 9'(FP_EXP_BIAS + 31);
               if (in_mag == 32'd0) begin
                  out_data_d    = FP_POS_ZERO;
                  out_inexact_d = 1'b0;
               end
            end
         end
         NORM: begin
            if (!mag_q[31]) begin
               // A wide step is only taken when it cannot push the leading one out.
               if ((NORM_STEP > 1) && (mag_q[31 -: NORM_STEP] == '0)) begin
                  mag_d = mag_q << NORM_STEP;
                  exp_d = exp_q - 9'(NORM_STEP);
               end else begin
                  mag_d = mag_q << 1;
                  exp_d = exp_q - 9'd1;
               end
            end
         end
         ROUND: begin
            out_data_d    = {sign_q, rnd_exp_mant};
            out_inexact_d = rnd_inexact;
         end
         default: ;
      endcase
   end

   assign out_data    = out_data_q;
   assign out_inexact = out_inexact_q;

endmodule
